// File: rtl/bus_arbiter_mux.sv
// Two-master bus arbiter and shared-bus mux with registered read-select return path.
// Optional macro BUS_ARBITER_ROUND_ROBIN_EN: alternate the IDLE tie-break using a last_grant register.
module bus_arbiter_mux #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_dout,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_dout,
   output logic              m0_grant,
   output logic              m1_grant,
   output logic              s_wr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_din,
   input  logic              s0_sel,
   input  logic              s1_sel,
   input  logic              s2_sel,
   input  logic [DATA_W-1:0] s0_dout,
   input  logic [DATA_W-1:0] s1_dout,
   input  logic [DATA_W-1:0] s2_dout,
   output logic [DATA_W-1:0] m_din
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_M0 = 2'd1,
      GNT_M1 = 2'd2
   } state_t;

   state_t     state_reg;
   logic [2:0] rd_sel_reg;
   logic       idle_pick_m0;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
   // 1 = M1 owned last, so M0 wins the first tie after reset.
   logic last_grant_reg;
   assign idle_pick_m0 = m0_req && (!m1_req || last_grant_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_reg <= 1'b1;
      end else if (state_reg == GNT_M0) begin
         last_grant_reg <= 1'b0;
      end else if (state_reg == GNT_M1) begin
         last_grant_reg <= 1'b1;
      end
   end
`else
   assign idle_pick_m0 = m0_req;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         rd_sel_reg <= 3'b000;
      end else begin
         rd_sel_reg <= {s0_sel, s1_sel, s2_sel};
         case (state_reg)
            IDLE: begin
               if (idle_pick_m0) begin
                  state_reg <= GNT_M0;
               end else if (m1_req) begin
                  state_reg <= GNT_M1;
               end
            end
            GNT_M0: begin
               // Owner keeps the bus until it lets go; then hand over with no idle gap.
               if (!m0_req) begin
                  state_reg <= m1_req ? GNT_M1 : IDLE;
               end
            end
            GNT_M1: begin
               if (!m1_req) begin
                  state_reg <= m0_req ? GNT_M0 : IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign m0_grant = (state_reg == GNT_M0);
   assign m1_grant = (state_reg == GNT_M1);

   always_comb begin
      s_wr   = 1'b0;
      s_addr = '0;
      s_din  = '0;
      if (state_reg == GNT_M0) begin
         s_wr   = m0_wr;
         s_addr = m0_addr;
         s_din  = m0_dout;
      end else if (state_reg == GNT_M1) begin
         s_wr   = m1_wr;
         s_addr = m1_addr;
         s_din  = m1_dout;
      end
   end

   // Anything other than a clean one-hot select (including unmapped) returns zero.
   always_comb begin
      m_din = '0;
      case (rd_sel_reg)
         3'b100:  m_din = s0_dout;
         3'b010:  m_din = s1_dout;
         3'b001:  m_din = s2_dout;
         default: m_din = '0;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench for bus_arbiter_mux: vector table, hand-written corner sequences, random run vs. model.
module tb_bus_arbiter_mux;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              m0_req, m0_wr, m1_req, m1_wr;
   logic [ADDR_W-1:0] m0_addr, m1_addr;
   logic [DATA_W-1:0] m0_dout, m1_dout;
   logic              m0_grant, m1_grant, s_wr;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_din;
   logic              s0_sel, s1_sel, s2_sel;
   logic [DATA_W-1:0] s0_dout, s1_dout, s2_dout;
   logic [DATA_W-1:0] m_din;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_arbiter_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
      .m0_grant(m0_grant), .m1_grant(m1_grant),
      .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
      .s0_sel(s0_sel), .s1_sel(s1_sel), .s2_sel(s2_sel),
      .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout),
      .m_din(m_din)
   );

   typedef struct {
      logic              r0, w0, r1, w1;
      logic [ADDR_W-1:0] a0, a1;
      logic [DATA_W-1:0] d0, d1;
      logic              e_g0, e_g1, e_wr;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_din;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_wr = 0; m0_addr = '0; m0_dout = '0;
      m1_req = 0; m1_wr = 0; m1_addr = '0; m1_dout = '0;
      s0_sel = 0; s1_sel = 0; s2_sel = 0;
      s0_dout = '0; s1_dout = '0; s2_dout = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
      tick();
   endtask

   function automatic vec_t mk(input logic r0, input logic r1, input logic [1:0] own);
      vec_t v;
      v.r0 = r0; v.w0 = 1'b1; v.a0 = 16'h0010; v.d0 = 32'hA5;
      v.r1 = r1; v.w1 = 1'b0; v.a1 = 16'h2008; v.d1 = 32'h1234_5678;
      v.e_g0 = (own == 2'd1);
      v.e_g1 = (own == 2'd2);
      v.e_wr = (own == 2'd1) ? v.w0 : (own == 2'd2) ? v.w1 : 1'b0;
      v.e_addr = (own == 2'd1) ? v.a0 : (own == 2'd2) ? v.a1 : '0;
      v.e_din = (own == 2'd1) ? v.d0 : (own == 2'd2) ? v.d1 : '0;
      return v;
   endfunction

   // Reference model state: owner 0 = nobody, 1 = M0, 2 = M1; last is the most recent owner.
   int owner;
   int last_owner;

   function automatic int next_owner(input int cur, input int last, input bit r0, input bit r1);
      bit tie_to_m1;
      if (cur == 1 && r0) return 1;
      if (cur == 2 && r1) return 2;
      if (cur == 1) return r1 ? 2 : 0;
      if (cur == 2) return r0 ? 1 : 0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      tie_to_m1 = (last == 1);
`else
      tie_to_m1 = 1'b0;
`endif
      if (r0 && r1) return tie_to_m1 ? 2 : 1;
      if (r0) return 1;
      if (r1) return 2;
      return 0;
   endfunction

   vec_t vecs[8];

   initial begin
      int  sel_pick;
      bit  r0, r1;
      logic [DATA_W-1:0] exp_din;

      reset = 1;
      idle_inputs();
      #1;
      chk("reset_g0", m0_grant, 0);
      chk("reset_g1", m1_grant, 0);
      chk("reset_addr", s_addr, 0);
      do_reset();
      chk("post_reset_idle_g0", m0_grant, 0);
      chk("post_reset_idle_g1", m1_grant, 0);

      // Table: request pattern applied before an edge, owner expected after it.
      vecs[0] = mk(0, 0, 0);
      vecs[1] = mk(1, 1, 1);   // tie from reset: M0 in both arbitration modes
      vecs[2] = mk(1, 1, 1);
      vecs[3] = mk(0, 1, 2);   // hand-over, no idle cycle
      vecs[4] = mk(0, 1, 2);
      vecs[5] = mk(1, 1, 2);   // no preemption
      vecs[6] = mk(1, 0, 1);
      vecs[7] = mk(0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         m0_req = vecs[i].r0; m0_wr = vecs[i].w0; m0_addr = vecs[i].a0; m0_dout = vecs[i].d0;
         m1_req = vecs[i].r1; m1_wr = vecs[i].w1; m1_addr = vecs[i].a1; m1_dout = vecs[i].d1;
         tick();
         chk($sformatf("vec%0d_g0", i), m0_grant, vecs[i].e_g0);
         chk($sformatf("vec%0d_g1", i), m1_grant, vecs[i].e_g1);
         chk($sformatf("vec%0d_wr", i), s_wr, vecs[i].e_wr);
         chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_din", i), s_din, vecs[i].e_din);
         $display("vec %0d: req=%b%b grant=%b%b s_addr=%h", i, vecs[i].r0, vecs[i].r1,
                  m0_grant, m1_grant, s_addr);
      end

      // Reset mid-tenure under M1 with a live read select: clear must be immediate.
      do_reset();
      m1_req = 1; m1_addr = 16'h1004; m1_wr = 1; m1_dout = 32'hDEAD;
      s1_sel = 1; s1_dout = 32'h5555_AAAA;
      tick();
      tick();
      chk("pre_reset_g1", m1_grant, 1);
      chk("pre_reset_addr", s_addr, 16'h1004);
      chk("pre_reset_mdin", m_din, 32'h5555_AAAA);
      reset = 1;
      #1;
      chk("async_g1", m1_grant, 0);
      chk("async_addr", s_addr, 0);
      chk("async_wr", s_wr, 0);
      chk("async_din", s_din, 0);
      chk("async_mdin", m_din, 0);
      $display("async reset mid-tenure: grant=%b%b s_addr=%h m_din=%h", m0_grant, m1_grant, s_addr, m_din);
      idle_inputs();
      tick();
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("after_reset_stays_idle", {m0_grant, m1_grant}, 2'b00);
      end

      // Read return: select sampled at one edge, data appears after it.
      m1_req = 1; m1_wr = 0; m1_addr = 16'h2008;
      tick();
      chk("read_g1", m1_grant, 1);
      s2_sel = 1; s2_dout = 32'h0000_0078;
      tick();
      chk("read_mdin", m_din, 32'h78);
      m1_addr = 16'h3000; s2_sel = 0;
      tick();
      chk("unmapped_mdin", m_din, 0);
      $display("read return: m_din=%h after unmapped", m_din);

      // No preemption: M0 waits out a 10-cycle M1 tenure, then takes over directly.
      m0_req = 1; m0_addr = 16'h0020;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("nopreempt_g0", m0_grant, 0);
         chk("nopreempt_g1", m1_grant, 1);
      end
      m1_req = 0;
      tick();
      chk("handover_g0", m0_grant, 1);
      chk("handover_addr", s_addr, 16'h0020);
      m0_req = 0;
      tick();

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      // Last owner was M0, so a tie from IDLE goes to M1, then back to M0.
      m0_req = 1; m1_req = 1;
      tick();
      chk("rr_tie1_g1", m1_grant, 1);
      m0_req = 0; m1_req = 0;
      tick();
      m0_req = 1; m1_req = 1;
      tick();
      chk("rr_tie2_g0", m0_grant, 1);
      m0_req = 0; m1_req = 0;
      tick();
`endif

      // Random run against the ownership model.
      do_reset();
      owner = 0;
      last_owner = 2;
      for (int c = 0; c < 400; c++) begin
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         m0_req = r0; m1_req = r1;
         m0_wr = 1'($urandom); m1_wr = 1'($urandom);
         m0_addr = 16'($urandom); m1_addr = 16'($urandom);
         m0_dout = $urandom; m1_dout = $urandom;
         s0_dout = $urandom; s1_dout = $urandom; s2_dout = $urandom;
         sel_pick = $urandom_range(0, 3);
         s0_sel = (sel_pick == 1); s1_sel = (sel_pick == 2); s2_sel = (sel_pick == 3);
         if (owner != 0) last_owner = owner;
         owner = next_owner(owner, last_owner, r0, r1);
         exp_din = (sel_pick == 1) ? s0_dout : (sel_pick == 2) ? s1_dout :
                   (sel_pick == 3) ? s2_dout : '0;
         tick();
         chk("rnd_g0", m0_grant, owner == 1);
         chk("rnd_g1", m1_grant, owner == 2);
         chk("rnd_wr", s_wr, (owner == 1) ? m0_wr : (owner == 2) ? m1_wr : 1'b0);
         chk("rnd_addr", s_addr, (owner == 1) ? m0_addr : (owner == 2) ? m1_addr : '0);
         chk("rnd_din", s_din, (owner == 1) ? m0_dout : (owner == 2) ? m1_dout : '0);
         chk("rnd_mdin", m_din, exp_din);
      end
      $display("random run: 400 cycles done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
Two-master bus arbiter and shared-bus multiplexer for the factorial machine system bus. Grants one of two masters (M0 = testbench/host, M1 = DMA or factorial core) and drives the shared address, write-enable and write-data lines. The top 4 address bits feed the bus address decoder. The decoder's slave selects (S0/S1/S2) come back into this block, which returns registered read data to the masters.

Parameters:
ADDR_W, 16, shared bus address width; bits [ADDR_W-1:ADDR_W-4] go to the address decoder
DATA_W, 32, bus data width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 bus request, held for the whole tenure
m0_wr  input  1  master 0 write enable (1 = write, 0 = read)
m0_addr  input  ADDR_W  master 0 address
m0_dout  input  DATA_W  master 0 write data
m1_req  input  1  master 1 bus request
m1_wr  input  1  master 1 write enable
m1_addr  input  ADDR_W  master 1 address
m1_dout  input  DATA_W  master 1 write data
m0_grant  output  1  master 0 owns the bus
m1_grant  output  1  master 1 owns the bus
s_wr  output  1  shared bus write enable
s_addr  output  ADDR_W  shared bus address (upper 4 bits go to the decoder)
s_din  output  DATA_W  shared bus write data
s0_sel, s1_sel, s2_sel  input  1 each  slave selects returned by the address decoder
s0_dout, s1_dout, s2_dout  input  DATA_W each  slave read data, valid 1 cycle after the select
m_din  output  DATA_W  read data returned to both masters

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-high.
- FSM states: IDLE, GNT_M0, GNT_M1. State is a register; grants decode from the state.
  - m0_grant = (state == GNT_M0); m1_grant = (state == GNT_M1).
  - The two grants are never both 1.
- Transitions, evaluated on the rising edge:
  - IDLE: m0_req → GNT_M0; else m1_req → GNT_M1; else stay IDLE. Both requesting → GNT_M0 (fixed priority).
  - GNT_M0: stay while m0_req=1. When m0_req=0: m1_req → GNT_M1, else IDLE.
  - GNT_M1: stay while m1_req=1. When m1_req=0: m0_req → GNT_M0, else IDLE.
  - No preemption: an owner keeps the bus until it drops its request.
- Grant latency: a request seen at edge N asserts the grant after edge N (1 cycle from IDLE). On release with the other master waiting, ownership switches with zero idle cycles.
- Bus mux (combinational from state):
  - GNT_M0 → s_wr/s_addr/s_din = m0_wr/m0_addr/m0_dout.
  - GNT_M1 → the m1 signals.
  - IDLE → all zero. s_wr=0 guarantees no write while idle.
- Read return:
  - rd_sel[2:0] register samples {s0_sel, s1_sel, s2_sel} every cycle.
  - m_din = s0_dout / s1_dout / s2_dout per rd_sel, one-hot; rd_sel == 000 → m_din = 0.
  - Read data therefore appears 1 cycle after the address is on the bus.
- Reset (any time, including mid-tenure): state = IDLE, rd_sel = 000. Outputs: m0_grant=0, m1_grant=0, s_wr=0, s_addr=0, s_din=0, m_din=0.
- After reset release, arbitration restarts from IDLE. No stale grant survives.
- Unmapped address (decoder gives 000): the write goes to no slave; the following-cycle m_din = 0.

Optional Feature:
- Macro: BUS_ARBITER_ROUND_ROBIN_EN.
- Defined: a last_grant register (reset = M1, so M0 wins first) records the most recent owner.
  - IDLE with both requesting → grant the master that is not last_grant.
  - Release with the other master waiting is unchanged (hand-over).
- Undefined: fixed M0 priority in IDLE as above; no last_grant register.

Test Plan:
1. Reset: assert reset mid-tenure (GNT_M1, s_addr=16'h1004) → same-cycle async clear: grants 0, s_addr=0, s_wr=0, m_din=0. After release, with no requests, stays IDLE.
2. Single master write: m0_req=1, m0_wr=1, m0_addr=16'h0010, m0_dout=32'hA5 → m0_grant=1 the next cycle; s_addr=16'h0010, s_din=32'hA5, s_wr=1. Drop m0_req → IDLE, s_wr=0.
3. Contention: m0_req and m1_req both rise from IDLE → GNT_M0 (macro undefined). Drop m0_req → m1_grant=1 on the next edge, no IDLE cycle; s_addr switches to m1_addr.
4. Read return: M1 reads 16'h2008 with s2_sel=1, s2_dout=32'h00000078 → m_din=32'h78 one cycle after the address; rd_sel=000 on an unmapped address 16'h3000 → m_din=0.
5. No preemption: M1 holds m1_req for 10 cycles while m0_req=1 → m0_grant stays 0 throughout; M0 is granted only after m1_req drops.
6. With BUS_ARBITER_ROUND_ROBIN_EN: M0 tenure ends to IDLE, then both request simultaneously → GNT_M1. Next simultaneous request from IDLE → GNT_M0.
